// File: rtl/uart_rx.sv
// uart_rx: oversampled asynchronous serial receiver (start, DATA_BITS data
// bits LSB first, optional parity, one stop bit). Each completed frame is
// reported with a one-cycle rx_valid strobe plus frame/parity error flags.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data
// and drives parity_err; without it parity_err is constant 0).
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a tick that sees rx_s low
// START  | counting to the middle of the start bit to reject glitches
// DATA   | sampling data bits at mid-bit, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit and publishing the frame
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // Two-flop synchronizer for the asynchronous line; idles high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and published outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic; nothing advances unless rx_tick is high.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif
    if (rx_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == TC_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A line that is high again at mid start bit was only a glitch.
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == TC_FULL) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == TC_FULL) begin
            tick_cnt_d = '0;
            par_bit_d  = rx_s_q;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt_q == TC_FULL) begin
            tick_cnt_d   = '0;
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            frame_err_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            parity_err_d = ((^shift_q) ^ par_bit_q) != PARITY_ODD;
`endif
            // Leaving at mid stop bit gives half a bit of margin for a
            // back-to-back start; a low stop bit parks in BREAK instead.
            state_d      = rx_s_q ? S_IDLE : S_BREAK;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are described at bit level, their
// expected outcome is queued when issued, and a monitor pops on rx_valid.
module tb_uart_rx;

  localparam int DB   = 8;
  localparam int OS   = 16;
  localparam bit PODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, busy;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Tick generator: one pulse every tick_div clocks.
  int tick_div = 1;
  int tick_ph  = 0;
  always @(negedge clk) begin
    if (tick_ph + 1 >= tick_div) begin
      tick_ph = 0;
      rx_tick = 1'b1;
    end else begin
      tick_ph = tick_ph + 1;
      rx_tick = 1'b0;
    end
  end

  typedef struct {
    logic [DB-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference rules: parity error when data+parity ones-count disagrees with
  // the configured sense; correct parity bit is the one making it agree.
  function automatic logic model_perr(input logic [DB-1:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    ones += int'(p);
    return ((ones % 2) == 1) != PODD;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic good_par(input logic [DB-1:0] d);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return ((ones % 2) == 1) != PODD;
  endfunction

  // Monitor: every rx_valid must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got strobe with rx_data=0x%0h, required none (t=%0t)",
                 rx_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
      end
    end
  end

  // Returns on the negedge after the n-th tick.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      do @(posedge clk); while (rx_tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic pbit);
    exp_t e;
    e.data = d;
    e.ferr = ~stop_b;
    e.perr = model_perr(d, pbit);
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop_b);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DB-1:0] d;
    logic          p;
    int            gap;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    rx  = 1'b1;
    wait_ticks(2 * OS);

    // Plain byte.
    send_frame(8'h55, 1'b1, good_par(8'h55));
    wait_ticks(OS);
    chk("idle_busy_after_55", 32'(busy), 32'h0);
    chk("held_data_55", 32'(rx_data), 32'h55);

    // Start glitch: four ticks low, then high again.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(2 * OS);
    chk("glitch_busy", 32'(busy), 32'h0);
    chk("glitch_data_held", 32'(rx_data), 32'h55);
    chk("glitch_ferr_held", 32'(frame_err), 32'h0);

    // Low stop bit followed by a long break.
    send_frame(8'hA3, 1'b0, good_par(8'hA3));
    rx = 1'b0;
    wait_ticks(40 * OS);
    chk("break_busy", 32'(busy), 32'h1);
    chk("break_ferr_held", 32'(frame_err), 32'h1);
    rx = 1'b1;
    wait_ticks(OS);
    chk("break_released_busy", 32'(busy), 32'h0);
    send_frame(8'h0F, 1'b1, good_par(8'h0F));
    rx = 1'b1;
    wait_ticks(OS);

    // Back-to-back frames with a slow tick.
    tick_div = 3;
    send_frame(8'h12, 1'b1, good_par(8'h12));
    send_frame(8'h34, 1'b1, good_par(8'h34));
    send_frame(8'hFF, 1'b1, good_par(8'hFF));
    rx = 1'b1;
    wait_ticks(2 * OS);
    tick_div = 1;
    wait_ticks(OS);

    // Reset in the middle of data bit 4 of 0x99; no strobe may result.
    d = 8'h99;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    wait_ticks(OS / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    rx = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    rx = 1'b1;
    wait_ticks(OS);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    wait_ticks(OS);
`endif

    // Randomized frames, tick rates and idle gaps.
    for (int n = 0; n < 24; n++) begin
      tick_div = int'($urandom_range(1, 3));
      gap      = int'($urandom_range(0, 2));
      d        = DB'($urandom);
`ifdef UART_RX_PARITY_EN
      p = 1'($urandom_range(0, 1));
`else
      p = good_par(d);
`endif
      rx = 1'b1;
      if (gap > 0) wait_ticks(gap * OS);
      send_frame(d, 1'b1, p);
    end
    rx = 1'b1;
    wait_ticks(2 * OS);

    for (int k = 0; k < 5000; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("final_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
